// File: rtl/cci_rd_reorder_pkg.sv
// Shared types and defaults for the CCI-P c0 read-response reorder buffer.
package cci_rd_reorder_pkg;
    localparam int DEPTH      = 64;
    localparam int DATA_WIDTH = 512;
    localparam int TAG_WIDTH  = 16;
    localparam int IDX_WIDTH  = 32;

    typedef logic [$clog2(DEPTH)-1:0] t_rob_slot;
    typedef logic [IDX_WIDTH-1:0]     t_rob_idx;
endpackage

// File: rtl/cci_rd_reorder_mem.sv
// Line storage: one write port, one registered read port. A write to the slot
// being read in the same cycle is forwarded so the prefetched line is never stale.
module cci_rd_reorder_mem
    import cci_rd_reorder_pkg::*;
#(
    parameter int DEPTH      = cci_rd_reorder_pkg::DEPTH,
    parameter int DATA_WIDTH = cci_rd_reorder_pkg::DATA_WIDTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i)
            mem_q[wr_addr_i] <= wr_data_i;
        if (wr_en_i && (wr_addr_i == rd_addr_i))
            rd_data_q <= wr_data_i;
        else
            rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/cci_rd_reorder_buf.sv
// Reorder buffer: tags outgoing reads, captures responses by tag, releases lines in
// request order with a sequential index. Define CCI_RD_REORDER_BUF_CHECK_EN for rsp_err.
module cci_rd_reorder_buf
    import cci_rd_reorder_pkg::*;
#(
    parameter int DEPTH      = cci_rd_reorder_pkg::DEPTH,
    parameter int DATA_WIDTH = cci_rd_reorder_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH  = cci_rd_reorder_pkg::TAG_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   alloc_ready_o,
    input  logic                   alloc_en_i,
    output logic [TAG_WIDTH-1:0]   alloc_tag_o,
    input  logic                   rsp_valid_i,
    input  logic [TAG_WIDTH-1:0]   rsp_tag_i,
    input  logic [DATA_WIDTH-1:0]  rsp_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  out_data_o,
    output logic [31:0]            out_idx_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   rsp_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DEPTH-1:0]      rdy_q, rdy_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    t_rob_idx              out_idx_q, out_idx_d;

    logic                  alloc_ready, alloc_ok, xfer, load, rsp_wr;
    logic [AW-1:0]         rsp_slot, rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_tag_hi;

    assign rsp_slot      = rsp_tag_i[AW-1:0];
    assign unused_tag_hi = ^rsp_tag_i[TAG_WIDTH-1:AW];
    assign alloc_ready   = (count_q != CW'(DEPTH));

    always_comb begin
        alloc_ok    = alloc_en_i && alloc_ready;
        xfer        = out_valid_q && out_ready_i;
        load        = rdy_q[head_q] && (!out_valid_q || xfer);
        tail_d      = tail_q + AW'(alloc_ok);
        head_d      = head_q + AW'(load);
        // Slot stays counted until the consumer takes the line, not when it is loaded.
        count_d     = count_q + CW'(alloc_ok) - CW'(xfer);
        out_valid_d = load || (out_valid_q && !xfer);
        out_idx_d   = out_idx_q + t_rob_idx'(xfer);
        rdy_d       = rdy_q;
        if (rsp_wr)
            rdy_d[rsp_slot] = 1'b1;
        if (load)
            rdy_d[head_q] = 1'b0;
    end

`ifdef CCI_RD_REORDER_BUF_CHECK_EN
    logic [DEPTH-1:0] inflight_q, inflight_d;
    logic             rsp_err_q, rsp_err_d;

    always_comb begin
        inflight_d = inflight_q;
        if (rsp_valid_i)
            inflight_d[rsp_slot] = 1'b0;
        if (alloc_ok)
            inflight_d[tail_q] = 1'b1;
        rsp_err_d = rsp_err_q
                    || (rsp_valid_i && !inflight_q[rsp_slot])
                    || (alloc_en_i && !alloc_ready);
    end

    assign rsp_wr = rsp_valid_i && inflight_q[rsp_slot];

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_wr    = rsp_valid_i;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rdy_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rdy_q       <= rdy_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load)
            out_data_q <= rd_data;
    end

    // Read port tracks the slot the next load will take, so the line is already registered.
    assign rd_addr = reset ? '0 : head_d;

    cci_rd_reorder_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (rsp_wr),
        .wr_addr_i (rsp_slot),
        .wr_data_i (rsp_data_i),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign alloc_ready_o = alloc_ready;
    assign alloc_tag_o   = TAG_WIDTH'(tail_q);
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_idx_o     = out_idx_q;
    assign count_o       = count_q;
endmodule

// File: tb/tb_cci_rd_reorder_buf.sv
// Scoreboard bench for cci_rd_reorder_buf at DEPTH=8; rsp_err expectations follow
// CCI_RD_REORDER_BUF_CHECK_EN.
module tb_cci_rd_reorder_buf;
    localparam int DEPTH = 8;
    localparam int DW    = 512;
    localparam int TW    = 16;
`ifdef CCI_RD_REORDER_BUF_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0]   idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_push   = 0;

    logic          clk = 1'b0, reset = 1'b1;
    logic          alloc_ready, alloc_en = 1'b0;
    logic [TW-1:0] alloc_tag;
    logic          rsp_valid = 1'b0;
    logic [TW-1:0] rsp_tag = '0;
    logic [DW-1:0] rsp_data = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [31:0]   out_idx;
    logic [3:0]    count;
    logic          rsp_err;

    cci_rd_reorder_buf #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .alloc_ready_o(alloc_ready), .alloc_en_i(alloc_en), .alloc_tag_o(alloc_tag),
        .rsp_valid_i(rsp_valid), .rsp_tag_i(rsp_tag), .rsp_data_i(rsp_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_idx_o(out_idx), .count_o(count), .rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkd(input int v);
        return {16{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; alloc_en = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        sb.delete();
        n_push = 0;
    endtask

    task automatic alloc(input logic [DW-1:0] d);
        alloc_en = 1'b1;
        sb.push_back('{idx: n_push, data: d});
        n_push++;
        tick();
        alloc_en = 1'b0;
    endtask

    task automatic respond(input int tag, input logic [DW-1:0] d);
        rsp_valid = 1'b1; rsp_tag = TW'(tag); rsp_data = d;
        tick();
        rsp_valid = 1'b0;
    endtask

    // In-order scoreboard: every transfer must match the oldest outstanding request.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL spurious_out got idx=%0d data=%h, required no output", out_idx, out_data[31:0]);
            end else begin
                e = sb.pop_front();
                if (out_idx !== e.idx || out_data !== e.data) begin
                    failures++;
                    $display("FAIL sb_order got idx=%0d data=%h, required idx=%0d data=%h",
                             out_idx, out_data[31:0], e.idx, e.data[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; tick(); tick();
        checks++;
        if (alloc_ready !== 1'b1 || alloc_tag !== 16'd0 || count !== 4'd0 || out_valid !== 1'b0 ||
            out_idx !== 32'd0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals got rdy=%b tag=%0d cnt=%0d ov=%b idx=%0d err=%b, required 1 0 0 0 0 0",
                     alloc_ready, alloc_tag, count, out_valid, out_idx, rsp_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_in_order();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (alloc_tag !== 16'(i)) begin
                failures++; $display("FAIL t1_tag got=%0d required=%0d", alloc_tag, i);
            end
            alloc(mkd(32'hA0 + i));
        end
        for (int i = 0; i < 4; i++) begin
            respond(i, mkd(32'hA0 + i));
            if (i < 2) begin
                checks++;
                if (out_valid !== 1'(i == 1)) begin
                    failures++; $display("FAIL t1_latency step=%0d got ov=%b required=%b", i, out_valid, i == 1);
                end
            end
        end
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        tick();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0 || count !== 4'd0) begin
            failures++;
            $display("FAIL t1_drain got left=%0d ov=%b cnt=%0d, required 0 0 0", sb.size(), out_valid, count);
        end
    endtask

    task automatic test_reverse();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (alloc_tag !== 16'(i)) begin
                failures++; $display("FAIL t2_tag got=%0d required=%0d", alloc_tag, i);
            end
            alloc(mkd(32'hB0 + i));
        end
        for (int t = 7; t >= 0; t--) begin
            respond(t, mkd(32'hB0 + t));
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL t2_early tag=%0d got ov=%b required=0", t, out_valid);
            end
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL t2_burst k=%0d got ov=%b required=1", k, out_valid);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            failures++; $display("FAIL t2_end got ov=%b left=%0d, required 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) alloc(mkd(32'h30 + i));
        checks++;
        if (alloc_ready !== 1'b0 || count !== 4'd8) begin
            failures++; $display("FAIL t3_full got rdy=%b cnt=%0d, required 0 8", alloc_ready, count);
        end
        alloc_en = 1'b1; tick(); alloc_en = 1'b0;
        checks++;
        if (count !== 4'd8 || alloc_tag !== 16'd0 || rsp_err !== CHK) begin
            failures++;
            $display("FAIL t3_overalloc got cnt=%0d tag=%0d err=%b, required 8 0 %b", count, alloc_tag, rsp_err, CHK);
        end
        for (int i = 0; i < 8; i++) respond(i, mkd(32'h30 + i));
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 32'd0 || out_data !== mkd(32'h30)) begin
                failures++;
                $display("FAIL t3_hold got ov=%b idx=%0d data=%h, required 1 0 00000030", out_valid, out_idx, out_data[31:0]);
            end
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++;
        if (alloc_ready !== 1'b1 || alloc_tag !== 16'd0 || count !== 4'd7 || out_idx !== 32'd1) begin
            failures++;
            $display("FAIL t3_release got rdy=%b tag=%0d cnt=%0d idx=%0d, required 1 0 7 1", alloc_ready, alloc_tag, count, out_idx);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 7; i++) alloc(mkd(32'hC0 + i));
        for (int i = 0; i < 7; i++) respond(i, mkd(32'hC0 + i));
        tick(); tick();
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (alloc_tag !== 16'((7 + c) % 8) || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL t4_tag c=%0d got tag=%0d ov=%b, required %0d 1", c, alloc_tag, out_valid, (7 + c) % 8);
            end
            alloc_en = 1'b1;
            sb.push_back('{idx: n_push, data: mkd(32'hC0 + 7 + c)});
            n_push++;
            rsp_valid = (c > 0);
            rsp_tag   = TW'((6 + c) % 8);
            rsp_data  = mkd(32'hC0 + 6 + c);
            tick();
            checks++;
            if (count !== 4'd7) begin
                failures++; $display("FAIL t4_count c=%0d got=%0d required=7", c, count);
            end
        end
        alloc_en = 1'b0;
        checks++;
        if (out_idx !== 32'd20) begin
            failures++; $display("FAIL t4_idx got=%0d required=20", out_idx);
        end
        respond(26 % 8, mkd(32'hC0 + 26));
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL t4_drain got left=%0d required=0", sb.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_dup_rsp();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) alloc(mkd(32'hD0 + i));
        respond(2, mkd(32'hD2));
        respond(2, mkd(32'hD2));
        checks++;
        if (rsp_err !== CHK) begin
            failures++; $display("FAIL t5_err got=%b required=%b", rsp_err, CHK);
        end
        respond(0, mkd(32'hD0));
        respond(1, mkd(32'hD1));
        respond(3, mkd(32'hD3));
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        tick();
        checks++;
        if (sb.size() != 0 || rsp_err !== CHK || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL t5_sticky got left=%0d err=%b ov=%b, required 0 %b 0", sb.size(), rsp_err, out_valid, CHK);
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        for (int i = 0; i < 3; i++) alloc(mkd(32'hE0 + i));
        respond(0, mkd(32'hE0));
        tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || count !== 4'd3) begin
            failures++; $display("FAIL t6_pre got ov=%b cnt=%0d, required 1 3", out_valid, count);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        sb.delete(); n_push = 0;
        checks++;
        if (alloc_ready !== 1'b1 || alloc_tag !== 16'd0 || count !== 4'd0 || out_valid !== 1'b0 ||
            out_idx !== 32'd0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL t6_reset got rdy=%b tag=%0d cnt=%0d ov=%b idx=%0d err=%b, required 1 0 0 0 0 0",
                     alloc_ready, alloc_tag, count, out_valid, out_idx, rsp_err);
        end
        respond(1, mkd(32'hEE));
        tick(); tick();
        checks++;
        if (rsp_err !== CHK || out_valid !== 1'b0) begin
            failures++; $display("FAIL t6_stale got err=%b ov=%b, required %b 0", rsp_err, out_valid, CHK);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_reverse();
        test_full();
        test_back_to_back();
        test_dup_rsp();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1);
    end
endmodule
